// File: rtl/exp_backoff_multi.sv
// Multi-channel randomized exponential backoff: one LFSR-driven wait counter per requester,
// with growing wait masks, retry limit/give-up flag, countdown prescale and global flush.
module exp_backoff_multi #(
    parameter int          NumCh      = 4,
    parameter int          Width      = 16,
    parameter int          MaxExp     = 16,
    parameter int          MinExp     = 0,
    parameter int          MaxRetries = 0,
    parameter logic [31:0] Seed       = 32'hACE1_0001
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             tick_i,
    input  logic [NumCh-1:0] set_i,
    input  logic [NumCh-1:0] clr_i,
    output logic [NumCh-1:0] is_zero_o,
    output logic [NumCh-1:0] give_up_o
);

    localparam int              RetW    = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam logic [RetW-1:0] RetMax  = RetW'(MaxRetries);
    localparam logic [Width-1:0] MaxMask = Width'((64'd1 << MaxExp) - 64'd1);
    localparam logic [Width-1:0] MinMask = Width'((64'd1 << (MinExp + 1)) - 64'd1);
    localparam logic [Width-1:0] CntOne  = Width'(1);

    if (Width < 4 || Width > 32) begin : g_badWidth
        $error("exp_backoff_multi: Width must be in 4..32");
    end
    if (MaxExp < 1 || MaxExp > Width) begin : g_badMaxExp
        $error("exp_backoff_multi: MaxExp must be in 1..Width");
    end
    if (MinExp < 0 || MinExp >= MaxExp) begin : g_badMinExp
        $error("exp_backoff_multi: MinExp must be in 0..MaxExp-1");
    end
    if (NumCh < 1) begin : g_badNumCh
        $error("exp_backoff_multi: NumCh must be at least 1");
    end
    if (Seed == 32'h0) begin : g_badSeed
        $error("exp_backoff_multi: Seed must be nonzero");
    end

    // Each channel gets a distinct golden-ratio-scrambled seed so their draws decorrelate.
    function automatic logic [31:0] seedOf(input int c);
        logic [31:0] s;
        s = Seed ^ (32'(c + 1) * 32'h9E37_79B9);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    logic [31:0]      r_lfsr [NumCh];
    logic [Width-1:0] r_mask [NumCh];
    logic [Width-1:0] r_cnt  [NumCh];
    logic [RetW-1:0]  r_ret  [NumCh];

    logic [31:0]      w_lfsrNext [NumCh];
    logic [Width-1:0] w_maskNext [NumCh];
    logic [Width-1:0] w_cntNext  [NumCh];
    logic [RetW-1:0]  w_retNext  [NumCh];
    logic [Width-1:0] w_maskGrow [NumCh];

    always_comb begin
        for (int c = 0; c < NumCh; c++) begin
            w_lfsrNext[c] = {r_lfsr[c][30:0],
                             r_lfsr[c][31] ^ r_lfsr[c][21] ^ r_lfsr[c][1] ^ r_lfsr[c][0]};
            w_maskGrow[c] = (r_mask[c] == '0) ? MinMask
                                              : (((r_mask[c] << 1) | CntOne) & MaxMask);
            w_maskNext[c] = r_mask[c];
            w_cntNext[c]  = r_cnt[c];
            w_retNext[c]  = r_ret[c];
            if (flush_i || clr_i[c]) begin
                w_maskNext[c] = '0;
                w_cntNext[c]  = '0;
                w_retNext[c]  = '0;
            end else if (set_i[c]) begin
                // The freshly grown mask gates the draw in the same cycle it is adopted.
                w_maskNext[c] = w_maskGrow[c];
                w_cntNext[c]  = w_maskGrow[c] & r_lfsr[c][Width-1:0];
                if (MaxRetries != 0 && r_ret[c] != RetMax) begin
                    w_retNext[c] = r_ret[c] + RetW'(1);
                end
            end else if (tick_i && r_cnt[c] != '0) begin
                w_cntNext[c] = r_cnt[c] - CntOne;
            end
        end
    end

    // The LFSR free-runs regardless of flush so draws stay unpredictable after a flush.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumCh; c++) begin
            if (rst_i) begin
                r_lfsr[c] <= seedOf(c);
                r_mask[c] <= '0;
                r_cnt[c]  <= '0;
                r_ret[c]  <= '0;
            end else begin
                r_lfsr[c] <= w_lfsrNext[c];
                r_mask[c] <= w_maskNext[c];
                r_cnt[c]  <= w_cntNext[c];
                r_ret[c]  <= w_retNext[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NumCh; c++) begin
            is_zero_o[c] = (r_cnt[c] == '0);
            give_up_o[c] = (MaxRetries != 0) && (r_ret[c] == RetMax);
        end
    end

endmodule

// File: tb/tb_exp_backoff_multi.sv
// Scoreboard bench for exp_backoff_multi: an LFSR/mask model predicts each drawn count,
// and the bench times is_zero_o against it.
module tb_exp_backoff_multi;

    localparam logic [31:0] Seed = 32'hACE1_0001;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       flush_i = 1'b0;
    logic       tick_i = 1'b0;
    logic [3:0] set_i = '0;
    logic [3:0] clr_i = '0;
    logic [3:0] is_zero_o;
    logic [3:0] give_up_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] mlfsr [4];
    logic [15:0] tm [4];
    int          expQ[$];

    exp_backoff_multi #(
        .NumCh(4), .Width(16), .MaxExp(4), .MinExp(0), .MaxRetries(3), .Seed(Seed)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .tick_i(tick_i),
        .set_i(set_i), .clr_i(clr_i), .is_zero_o(is_zero_o), .give_up_o(give_up_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] seedOf(input int c);
        logic [31:0] s;
        s = Seed ^ (32'(c + 1) * 32'h9E37_79B9);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [15:0] growMask(input logic [15:0] m);
        return (m == 16'h0) ? 16'h1 : (((m << 1) | 16'h1) & 16'hF);
    endfunction

    // Reference LFSR: reseeded on reset edges, otherwise stepped every edge.
    always @(posedge clk_i) begin
        for (int c = 0; c < 4; c++) begin
            if (rst_i) mlfsr[c] = seedOf(c);
            else mlfsr[c] = {mlfsr[c][30:0], mlfsr[c][31] ^ mlfsr[c][21] ^ mlfsr[c][1] ^ mlfsr[c][0]};
        end
    end

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulseSet(input int c, output int expCnt);
        set_i[c] = 1'b1;
        tm[c] = growMask(tm[c]);
        expCnt = int'(tm[c] & mlfsr[c][15:0]);
        stepCycle();
        set_i[c] = 1'b0;
    endtask

    task automatic pulseSetAll(output int expCnt [4]);
        set_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            tm[c] = growMask(tm[c]);
            expCnt[c] = int'(tm[c] & mlfsr[c][15:0]);
        end
        stepCycle();
        set_i = 4'h0;
    endtask

    task automatic pulseClr(input logic [3:0] chans);
        clr_i = chans;
        stepCycle();
        clr_i = 4'h0;
        for (int c = 0; c < 4; c++) if (chans[c]) tm[c] = 16'h0;
    endtask

    task automatic waitLowBits(input int c, input logic [3:0] msk, input logic [3:0] val);
        int n;
        n = 0;
        while (((mlfsr[c][3:0] & msk) != val) && n < 300) begin
            stepCycle();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("[TB] FAIL wait_lfsr ch%0d: got timeout, expected low bits %0h", c, val);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        stepCycle();
        stepCycle();
        checks++;
        if (is_zero_o !== 4'hF) begin
            errors++; $display("[TB] FAIL reset_is_zero: got %b expected 1111", is_zero_o);
        end
        checks++;
        if (give_up_o !== 4'h0) begin
            errors++; $display("[TB] FAIL reset_give_up: got %b expected 0000", give_up_o);
        end
        checks++;
        if (dut.r_lfsr[0] !== (Seed ^ 32'h9E37_79B9)) begin
            errors++;
            $display("[TB] FAIL reset_lfsr0: got %h expected %h", dut.r_lfsr[0], Seed ^ 32'h9E37_79B9);
        end
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) tm[c] = 16'h0;
    endtask

    task automatic test_mask_growth();
        logic [15:0] maskTab [6];
        int e, n, exp;
        maskTab = '{16'h1, 16'h3, 16'h7, 16'hF, 16'hF, 16'hF};
        tick_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulseSet(0, e);
            expQ.push_back(e);
            checks++;
            if (dut.r_mask[0] !== maskTab[i]) begin
                errors++;
                $display("[TB] FAIL mask_growth_%0d: got %h expected %h", i, dut.r_mask[0], maskTab[i]);
            end
            n = 0;
            while (!is_zero_o[0] && n < 40) begin
                stepCycle();
                n++;
            end
            exp = expQ.pop_front();
            checks++;
            if (n !== exp) begin
                errors++;
                $display("[TB] FAIL countdown_%0d: got %0d cycles expected %0d", i, n, exp);
            end
            if (n < 19) repeat (19 - n) stepCycle();
        end
        checks++;
        if (give_up_o[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL growth_give_up: got %b expected 1", give_up_o[0]);
        end
        pulseClr(4'b0001);
    endtask

    task automatic test_prescale();
        int e, n, highs, exp, mcnt;
        bit phase;
        tick_i = 1'b0;
        pulseClr(4'b0010);
        for (int i = 0; i < 3; i++) pulseSet(1, e);
        waitLowBits(1, 4'h7, 4'h5);
        pulseSet(1, e);
        expQ.push_back(e);
        mcnt = e;
        n = 0;
        highs = 0;
        phase = 1'b1;
        while (!is_zero_o[1] && n < 40) begin
            tick_i = phase;
            stepCycle();
            n++;
            if (phase) begin
                highs++;
                mcnt--;
            end
            checks++;
            if (int'(dut.r_cnt[1]) !== mcnt) begin
                errors++;
                $display("[TB] FAIL prescale_cnt: got %0d expected %0d", dut.r_cnt[1], mcnt);
            end
            phase = !phase;
        end
        tick_i = 1'b0;
        exp = expQ.pop_front();
        checks++;
        if (highs !== exp) begin
            errors++; $display("[TB] FAIL prescale_ticks: got %0d expected %0d", highs, exp);
        end
        checks++;
        if (n !== 2 * exp - 1) begin
            errors++; $display("[TB] FAIL prescale_cycles: got %0d expected %0d", n, 2 * exp - 1);
        end
    endtask

    task automatic test_priority();
        int e, e0;
        tick_i = 1'b0;
        pulseClr(4'hF);
        pulseSet(0, e0);
        for (int i = 0; i < 4; i++) pulseSet(2, e);
        waitLowBits(2, 4'hF, 4'h9);
        pulseSet(2, e);
        checks++;
        if (int'(dut.r_cnt[2]) !== e) begin
            errors++; $display("[TB] FAIL priority_preload: got %0d expected %0d", dut.r_cnt[2], e);
        end
        set_i[2] = 1'b1;
        clr_i[2] = 1'b1;
        stepCycle();
        set_i[2] = 1'b0;
        clr_i[2] = 1'b0;
        tm[2] = 16'h0;
        checks++;
        if (dut.r_cnt[2] !== 16'h0 || dut.r_mask[2] !== 16'h0) begin
            errors++;
            $display("[TB] FAIL priority_clr: got cnt %0d mask %h expected 0 0", dut.r_cnt[2], dut.r_mask[2]);
        end
        checks++;
        if (is_zero_o[3:1] !== 3'b111) begin
            errors++; $display("[TB] FAIL priority_is_zero: got %b expected 111", is_zero_o[3:1]);
        end
        checks++;
        if (int'(dut.r_cnt[0]) !== e0) begin
            errors++; $display("[TB] FAIL priority_ch0_cnt: got %0d expected %0d", dut.r_cnt[0], e0);
        end
        checks++;
        if (give_up_o !== 4'h0) begin
            errors++; $display("[TB] FAIL priority_give_up: got %b expected 0000", give_up_o);
        end
    endtask

    task automatic test_give_up();
        int e;
        tick_i = 1'b1;
        pulseClr(4'b1000);
        for (int i = 1; i <= 3; i++) begin
            pulseSet(3, e);
            checks++;
            if (give_up_o[3] !== (i == 3)) begin
                errors++; $display("[TB] FAIL give_up_%0d: got %b expected %b", i, give_up_o[3], i == 3);
            end
            repeat (2) stepCycle();
        end
        tick_i = 1'b0;
        pulseSet(3, e);
        checks++;
        if (int'(dut.r_cnt[3]) !== e) begin
            errors++; $display("[TB] FAIL give_up_reload: got %0d expected %0d", dut.r_cnt[3], e);
        end
        checks++;
        if (give_up_o[3] !== 1'b1) begin
            errors++; $display("[TB] FAIL give_up_hold: got %b expected 1", give_up_o[3]);
        end
        pulseClr(4'b1000);
        checks++;
        if (give_up_o[3] !== 1'b0) begin
            errors++; $display("[TB] FAIL give_up_clr: got %b expected 0", give_up_o[3]);
        end
    endtask

    task automatic test_flush_reset();
        int e [4];
        tick_i = 1'b0;
        pulseClr(4'hF);
        for (int i = 0; i < 4; i++) pulseSetAll(e);
        flush_i = 1'b1;
        stepCycle();
        flush_i = 1'b0;
        for (int c = 0; c < 4; c++) tm[c] = 16'h0;
        checks++;
        if (is_zero_o !== 4'hF || give_up_o !== 4'h0) begin
            errors++;
            $display("[TB] FAIL flush_outputs: got %b/%b expected 1111/0000", is_zero_o, give_up_o);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (dut.r_mask[c] !== 16'h0 || dut.r_lfsr[c] !== mlfsr[c]) begin
                errors++;
                $display("[TB] FAIL flush_ch%0d: got mask %h lfsr %h expected 0 %h",
                         c, dut.r_mask[c], dut.r_lfsr[c], mlfsr[c]);
            end
        end
        for (int i = 0; i < 4; i++) pulseSetAll(e);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (int'(dut.r_cnt[c]) !== e[c]) begin
                errors++; $display("[TB] FAIL midcount_ch%0d: got %0d expected %0d", c, dut.r_cnt[c], e[c]);
            end
        end
        rst_i = 1'b1;
        stepCycle();
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tm[c] = 16'h0;
            checks++;
            if (dut.r_lfsr[c] !== seedOf(c)) begin
                errors++; $display("[TB] FAIL reset_reseed_ch%0d: got %h expected %h", c, dut.r_lfsr[c], seedOf(c));
            end
        end
        checks++;
        if (is_zero_o !== 4'hF || give_up_o !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_midcount: got %b/%b expected 1111/0000", is_zero_o, give_up_o);
        end
    endtask

    initial begin
        $display("[TB] starting exp_backoff_multi bench");
        test_reset();
        test_mask_growth();
        test_prescale();
        test_priority();
        test_give_up();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
